// File: rtl/sap1_pkg.sv
// Shared constants and types for the SAP-1 control sequencer.
// Optional build macro used by the top: SAP1_EARLY_END_EN.
package sap1_pkg;

  localparam int ONEHOT_W = 6;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h3;
  localparam logic [3:0] OP_DIV = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_HOLD = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_MUL  = 3'b011;
  localparam logic [2:0] ALU_DIV  = 3'b100;
  localparam logic [2:0] ALU_AND  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_XOR  = 3'b111;

  // Sequencer state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_T1   = 3'd1;
  localparam state_t ST_T2   = 3'd2;
  localparam state_t ST_T3   = 3'd3;
  localparam state_t ST_T4   = 3'd4;
  localparam state_t ST_T5   = 3'd5;
  localparam state_t ST_T6   = 3'd6;
  localparam state_t ST_HALT = 3'd7;

  typedef struct packed {
    logic                pcOut;
    logic                pcInc;
    logic                marLoad;
    logic                ramOut;
    logic                irLoad;
    logic                irOut;
    logic                accLoad;
    logic                accOut;
    logic                bLoad;
    logic                aluEn;
    logic                outLoad;
    logic [2:0]          aluSel;
    logic                halt;
    logic [ONEHOT_W-1:0] tState;
  } ctrl_t;

  function automatic logic isAluOp(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/sap1_control_decode.sv
// Combinational decode of (T-state, opcode) into the SAP-1 control word.
module sap1_control_decode
  import sap1_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_T1: begin
        ctrl.tState  = 6'b000001;
        ctrl.pcOut   = 1'b1;
        ctrl.marLoad = 1'b1;
      end
      ST_T2: begin
        ctrl.tState = 6'b000010;
        ctrl.pcInc  = 1'b1;
      end
      ST_T3: begin
        ctrl.tState = 6'b000100;
        ctrl.ramOut = 1'b1;
        ctrl.irLoad = 1'b1;
      end
      ST_T4: begin
        ctrl.tState = 6'b001000;
        if (opcode == OP_LDA || isAluOp(opcode)) begin
          ctrl.irOut   = 1'b1;
          ctrl.marLoad = 1'b1;
        end else if (opcode == OP_OUT) begin
          ctrl.accOut  = 1'b1;
          ctrl.outLoad = 1'b1;
        end
      end
      ST_T5: begin
        ctrl.tState = 6'b010000;
        if (opcode == OP_LDA) begin
          ctrl.ramOut  = 1'b1;
          ctrl.accLoad = 1'b1;
        end else if (isAluOp(opcode)) begin
          ctrl.ramOut = 1'b1;
          ctrl.bLoad  = 1'b1;
        end
      end
      ST_T6: begin
        ctrl.tState = 6'b100000;
        // The ALU select is the low three opcode bits for every ALU op
        if (isAluOp(opcode)) begin
          ctrl.aluEn   = 1'b1;
          ctrl.accLoad = 1'b1;
          ctrl.aluSel  = opcode[2:0];
        end
      end
      ST_HALT: ctrl.halt = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 T-state sequencer: state register, next-state logic and control outputs.
// Define SAP1_EARLY_END_EN to end LDA/OUT/NOP right after their last useful state.
module sap1_controller
  import sap1_pkg::*;
#(
  parameter int RING_LEN = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          instr,
  output logic                pcOut,
  output logic                pcInc,
  output logic                marLoad,
  output logic                ramOut,
  output logic                irLoad,
  output logic                irOut,
  output logic                accLoad,
  output logic                accOut,
  output logic                bLoad,
  output logic                aluEn,
  output logic                outLoad,
  output logic [2:0]          AluController,
  output logic                halt,
  output logic [RING_LEN-1:0] tState
);

  state_t     state;
  state_t     stateNext;
  logic [3:0] opcode;
  ctrl_t      ctrl;
  logic       unusedAddrBits;

  assign opcode         = instr[7:4];
  assign unusedAddrBits = ^instr[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= stateNext;
  end

  // Only T4 onward looks at the opcode; the IR is not valid before then
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: stateNext = ST_T1;
      ST_T1:   stateNext = ST_T2;
      ST_T2:   stateNext = ST_T3;
      ST_T3:   stateNext = ST_T4;
      ST_T4: begin
        if (opcode == OP_HLT) stateNext = ST_HALT;
`ifdef SAP1_EARLY_END_EN
        else if (opcode != OP_LDA && !isAluOp(opcode)) stateNext = ST_T1;
`endif
        else stateNext = ST_T5;
      end
      ST_T5: begin
`ifdef SAP1_EARLY_END_EN
        if (opcode == OP_LDA) stateNext = ST_T1;
        else                  stateNext = ST_T6;
`else
        stateNext = ST_T6;
`endif
      end
      ST_T6:   stateNext = ST_T1;
      ST_HALT: stateNext = ST_HALT;
      default: stateNext = ST_IDLE;
    endcase
  end

  sap1_control_decode u_decode (
    .state  (state),
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  assign pcOut         = ctrl.pcOut;
  assign pcInc         = ctrl.pcInc;
  assign marLoad       = ctrl.marLoad;
  assign ramOut        = ctrl.ramOut;
  assign irLoad        = ctrl.irLoad;
  assign irOut         = ctrl.irOut;
  assign accLoad       = ctrl.accLoad;
  assign accOut        = ctrl.accOut;
  assign bLoad         = ctrl.bLoad;
  assign aluEn         = ctrl.aluEn;
  assign outLoad       = ctrl.outLoad;
  assign AluController = ctrl.aluSel;
  assign halt          = ctrl.halt;
  assign tState        = ctrl.tState;

endmodule

// File: tb/tb_sap1_controller.sv
// Scoreboard bench for sap1_controller: driver queues expected control words, monitor compares each cycle.
module tb_sap1_controller;

  localparam logic [10:0] C_PCOUT   = 11'b100_0000_0000;
  localparam logic [10:0] C_PCINC   = 11'b010_0000_0000;
  localparam logic [10:0] C_MARLOAD = 11'b001_0000_0000;
  localparam logic [10:0] C_RAMOUT  = 11'b000_1000_0000;
  localparam logic [10:0] C_IRLOAD  = 11'b000_0100_0000;
  localparam logic [10:0] C_IROUT   = 11'b000_0010_0000;
  localparam logic [10:0] C_ACCLOAD = 11'b000_0001_0000;
  localparam logic [10:0] C_ACCOUT  = 11'b000_0000_1000;
  localparam logic [10:0] C_BLOAD   = 11'b000_0000_0100;
  localparam logic [10:0] C_ALUEN   = 11'b000_0000_0010;
  localparam logic [10:0] C_OUTLOAD = 11'b000_0000_0001;

  localparam int K_LDA = 0;
  localparam int K_ALU = 1;
  localparam int K_OUT = 2;
  localparam int K_NOP = 3;
  localparam int K_HLT = 4;

`ifdef SAP1_EARLY_END_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [20:0] v;
    string       tag;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] instr;
  logic       pcOut, pcInc, marLoad, ramOut, irLoad, irOut;
  logic       accLoad, accOut, bLoad, aluEn, outLoad, halt;
  logic [2:0] AluController;
  logic [5:0] tState;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   driverDone = 1'b0;

  sap1_controller #(.RING_LEN(6)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr         (instr),
    .pcOut         (pcOut),
    .pcInc         (pcInc),
    .marLoad       (marLoad),
    .ramOut        (ramOut),
    .irLoad        (irLoad),
    .irOut         (irOut),
    .accLoad       (accLoad),
    .accOut        (accOut),
    .bLoad         (bLoad),
    .aluEn         (aluEn),
    .outLoad       (outLoad),
    .AluController (AluController),
    .halt          (halt),
    .tState        (tState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] mk(input logic [5:0] ts, input logic [10:0] ctl,
                                     input logic [2:0] alu, input logic hlt);
    return {hlt, ctl, alu, ts};
  endfunction

  // Drive one cycle's input and queue what the DUT must show during it
  task automatic applyStimulus(input logic [7:0] ins, input logic [20:0] expv, input string tag);
    exp_t e;
    instr = ins;
    e.v   = expv;
    e.tag = tag;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic runInstr(input logic [7:0] ins, input int kind, input logic [2:0] expAlu,
                          input string tag);
    logic [10:0] t4;
    logic [10:0] t5;
    logic [10:0] t6;
    applyStimulus(8'($urandom), mk(6'b000001, C_PCOUT | C_MARLOAD, 3'b000, 1'b0), {tag, ".t1"});
    applyStimulus(8'($urandom), mk(6'b000010, C_PCINC, 3'b000, 1'b0), {tag, ".t2"});
    applyStimulus(8'($urandom), mk(6'b000100, C_RAMOUT | C_IRLOAD, 3'b000, 1'b0), {tag, ".t3"});
    t4 = '0;
    t5 = '0;
    t6 = '0;
    case (kind)
      K_LDA: begin t4 = C_IROUT | C_MARLOAD; t5 = C_RAMOUT | C_ACCLOAD; end
      K_ALU: begin t4 = C_IROUT | C_MARLOAD; t5 = C_RAMOUT | C_BLOAD; t6 = C_ALUEN | C_ACCLOAD; end
      K_OUT: t4 = C_ACCOUT | C_OUTLOAD;
      default: ;
    endcase
    applyStimulus(ins, mk(6'b001000, t4, 3'b000, 1'b0), {tag, ".t4"});
    if (kind == K_HLT) return;
    if (EARLY && (kind == K_OUT || kind == K_NOP)) return;
    applyStimulus(ins, mk(6'b010000, t5, 3'b000, 1'b0), {tag, ".t5"});
    if (EARLY && kind == K_LDA) return;
    applyStimulus(ins, mk(6'b100000, t6, (kind == K_ALU) ? expAlu : 3'b000, 1'b0), {tag, ".t6"});
  endtask

  // Monitor: compares the DUT against the oldest queued expectation each falling edge
  task automatic checkOutput();
    exp_t        e;
    logic [20:0] act;
    e   = expQ.pop_front();
    act = {halt, pcOut, pcInc, marLoad, ramOut, irLoad, irOut, accLoad, accOut, bLoad,
           aluEn, outLoad, AluController, tState};
    compared++;
    if (act !== e.v) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%b required=%b (halt|ctl11|alu3|tState6)", e.tag, act, e.v);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput();
    end
  end

  initial begin
    rst_n = 1'b0;
    instr = 8'h00;
    @(posedge clk);
    #1;
    repeat (3) applyStimulus(8'($urandom), '0, "resetLow");
    rst_n = 1'b1;
    applyStimulus(8'h00, '0, "idle");

    runInstr(8'h1A, K_ALU, 3'b001, "add1A");
    runInstr(8'h05, K_LDA, 3'b000, "lda05");
    runInstr(8'h23, K_ALU, 3'b010, "sub");
    runInstr(8'h3C, K_ALU, 3'b011, "mul");
    runInstr(8'h40, K_ALU, 3'b100, "div");
    runInstr(8'h5F, K_ALU, 3'b101, "and");
    runInstr(8'h67, K_ALU, 3'b110, "or");
    runInstr(8'h79, K_ALU, 3'b111, "xor");
    runInstr(8'hE3, K_OUT, 3'b000, "outE3");
    runInstr(8'h84, K_NOP, 3'b000, "nop8");
    runInstr(8'hD1, K_NOP, 3'b000, "nopD");

    // Program LDA, OUT, NOP, ADD; each next T1 pins the previous length
    runInstr(8'h0E, K_LDA, 3'b000, "progLda");
    runInstr(8'hE0, K_OUT, 3'b000, "progOut");
    runInstr(8'h90, K_NOP, 3'b000, "progNop");
    runInstr(8'h1F, K_ALU, 3'b001, "progAdd");

    // Asynchronous reset landing in the middle of T5 of LDA
    applyStimulus(8'($urandom), mk(6'b000001, C_PCOUT | C_MARLOAD, 3'b000, 1'b0), "midRst.t1");
    applyStimulus(8'($urandom), mk(6'b000010, C_PCINC, 3'b000, 1'b0), "midRst.t2");
    applyStimulus(8'($urandom), mk(6'b000100, C_RAMOUT | C_IRLOAD, 3'b000, 1'b0), "midRst.t3");
    applyStimulus(8'h05, mk(6'b001000, C_IROUT | C_MARLOAD, 3'b000, 1'b0), "midRst.t4");
    instr = 8'h05;
    #1;
    rst_n = 1'b0;
    applyStimulus(8'h05, '0, "midRst.t5abort");
    applyStimulus(8'h05, '0, "midRst.held");
    rst_n = 1'b1;
    applyStimulus(8'h05, '0, "midRst.idle");
    runInstr(8'h05, K_LDA, 3'b000, "afterRst");

    runInstr(8'hF0, K_HLT, 3'b000, "hlt");
    repeat (20) applyStimulus(8'($urandom), mk(6'b000000, 11'b0, 3'b000, 1'b1), "halted");
    rst_n = 1'b0;
    applyStimulus(8'hF0, '0, "haltRst");
    rst_n = 1'b1;
    applyStimulus(8'h1A, '0, "haltIdle");
    runInstr(8'h1A, K_ALU, 3'b001, "postHalt");
    driverDone = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!driverDone && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    repeat (2) @(posedge clk);
    if (!driverDone || expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain actual=%0d pending required=0 (driverDone=%0d)", expQ.size(), driverDone);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sap1_controller.md
# sap1_controller

Control sequencer for the SAP-1 processor. It steps a T-state machine through fetch and execute for each instruction, decodes the opcode held in the instruction register, and drives every datapath control line. The lines it drives are the bus enables, the register loads, the PC increment, halt, and the 3-bit `AluController` select consumed by the ALU. The block sits directly upstream of the ALU and the register file and is the only source of control in the datapath.

## Interface
- `RING_LEN`, default 6: number of execute-capable T-states. Fixed at 6; exposed for the bench only.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `instr` in 8: IR contents; opcode is `instr[7:4]`; `instr[3:0]` is an address and is unused here.
- `pcOut` out 1: PC drives the bus.
- `pcInc` out 1: PC increments.
- `marLoad` out 1: MAR loads from the bus.
- `ramOut` out 1: RAM drives the bus.
- `irLoad` out 1: IR loads from the bus.
- `irOut` out 1: IR low nibble drives the bus.
- `accLoad` out 1: accumulator loads from the bus.
- `accOut` out 1: accumulator drives the bus.
- `bLoad` out 1: B register loads.
- `aluEn` out 1: ALU result drives the bus.
- `outLoad` out 1: output register loads.
- `AluController` out 3: ALU operation select.
- `halt` out 1: processor halted, sticky.
- `tState` out 6: one-hot current T-state (T1 = bit 0); all zero in IDLE and HALT.

## Operation
- States: IDLE, T1–T6, HALT. Reset (async) forces IDLE.
- On the first edge after `rst_n` rises, IDLE → T1.
- The state advances T1 → T2 → … → T6 → T1 every cycle.
- Opcodes (`instr[7:4]`):
  - 0000 LDA.
  - 0001 ADD, 0010 SUB, 0011 MUL, 0100 DIV, 0101 AND, 0110 OR, 0111 XOR (together, the "ALU ops").
  - 1110 OUT.
  - 1111 HLT.
  - All others are NOP.
- Fetch, identical for all opcodes:
  - T1: `pcOut`, `marLoad`.
  - T2: `pcInc`.
  - T3: `ramOut`, `irLoad`.
- T4 by opcode:
  - LDA and ALU ops: `irOut`, `marLoad`.
  - OUT: `accOut`, `outLoad`.
  - HLT: next state is HALT.
  - NOP: no outputs.
- T5 by opcode:
  - LDA: `ramOut`, `accLoad`.
  - ALU ops: `ramOut`, `bLoad`.
  - All others: no outputs.
- T6 by opcode:
  - ALU ops: `aluEn`, `accLoad`, and `AluController = instr[6:4]` (ADD = 001 … XOR = 111).
  - All others: no outputs.
- `AluController` is 000 (ALU hold) in every state other than T6 of an ALU op.
- HALT:
  - All control outputs are 0 and `halt` = 1.
  - The state is held until `rst_n` is asserted; `instr` is ignored.
- Outputs are combinational decode of the registered state plus `instr[7:4]`. No output depends on `instr` during T1–T3.
- Reset value of every output is 0, including `halt`, `AluController` and `tState`.
- Reset mid-instruction aborts immediately to IDLE with all outputs 0. There is no partial completion.
- Unknown opcodes behave exactly as NOP; the block never deadlocks.

## Timing
- Each control output is asserted for exactly the one cycle of its T-state. The datapath samples it on the rising edge that ends that state.
- Instruction latency:
  - Fixed 6 cycles per instruction (T1–T6), HLT included up to T4.
  - HALT is entered on the edge ending T4 of HLT.
- IR is loaded on the edge ending T3, so `instr` is valid from T4 onward.
- The first instruction fetch starts 1 cycle after reset deassertion (the IDLE cycle).

## Configuration
- `SAP1_EARLY_END_EN` defined:
  - Variable-length cycle: the state returns to T1 after the last state that does useful work.
  - LDA: T5 → T1 (5 cycles).
  - OUT and NOP: T4 → T1 (4 cycles).
  - ALU ops: unchanged (6 cycles).
- Not defined: every instruction takes 6 cycles.
- Output decode per T-state is identical in both builds.

## Structure
- Shared package `sap1_pkg` holds:
  - opcode constants (`OP_LDA` … `OP_HLT`);
  - `AluController` encodings (`ALU_HOLD` = 000 … `ALU_XOR` = 111);
  - the state enum;
  - the one-hot width constant.
- One sub-module, `sap1_control_decode`: purely combinational, (state, opcode) → control word.
- The top holds the state register, next-state logic and the `SAP1_EARLY_END_EN` branch.

## Test plan
- Reset held low for 3 cycles, then released:
  - all outputs 0 while low;
  - IDLE cycle;
  - next cycle `tState` = 000001 with `pcOut` = `marLoad` = 1.
- `instr` = 0x1A (ADD):
  - T4 `irOut` + `marLoad`;
  - T5 `ramOut` + `bLoad`;
  - T6 `aluEn` + `accLoad` with `AluController` = 001;
  - `AluController` = 000 in all other states.
- Sweep opcodes 0001–0111: T6 `AluController` equals 001–111 respectively, with `aluEn` and `accLoad` = 1 in each case.
- `instr` = 0xF0 (HLT):
  - `halt` rises after T4;
  - all controls 0 and `tState` = 0 for 20 cycles while `instr` toggles randomly;
  - `rst_n` pulse returns to IDLE.
- `rst_n` asserted asynchronously mid-T5 of LDA (0x05): outputs drop to 0 before the next edge; fetch restarts at T1.
- With `SAP1_EARLY_END_EN`, program LDA, OUT, NOP, ADD: cycle counts are 5, 4, 4, 6. Without it, all four take 6 cycles.
